// File: rtl/seq_alu_acc_if.sv
// Request/response bundle for seq_alu_acc: operands and opcode toward the ALU,
// status and the accumulator value back.
interface seq_alu_acc_if #(
  parameter int WIDTH = 16
);
  logic                 start;
  logic [3:0]           op;
  logic                 use_acc;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic                 err;

  modport master (
    output start, op, use_acc, a, b,
    input  busy, done, result, err
  );

  modport slave (
    input  start, op, use_acc, a, b,
    output busy, done, result, err
  );
endinterface

// File: rtl/seq_alu_acc.sv
// Multi-cycle ALU with a 2*WIDTH accumulator. MUL, DIV and FACT iterate in EXEC;
// every other operation completes on the accept edge.
module seq_alu_acc #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  seq_alu_acc_if.slave bus
);

  localparam logic [3:0] OP_CLR  = 4'd0;
  localparam logic [3:0] OP_NOT  = 4'd1;
  localparam logic [3:0] OP_SHR  = 4'd2;
  localparam logic [3:0] OP_SHL  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_DIV  = 4'd10;
  localparam logic [3:0] OP_FACT = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [3:0]           op_reg, op_next;
  logic [WIDTH-1:0]     opa_reg, opa_next;
  logic [WIDTH-1:0]     opb_reg, opb_next;
  logic [WIDTH-1:0]     cnt_reg, cnt_next;
  logic [2*WIDTH-1:0]   mcand_reg, mcand_next;
  logic [WIDTH-1:0]     mplier_reg, mplier_next;
  logic [2*WIDTH-1:0]   prod_reg, prod_next;
  logic [WIDTH-1:0]     rem_reg, rem_next;
  logic [WIDTH-1:0]     quo_reg, quo_next;
  logic [2*WIDTH-1:0]   result_reg, result_next;
  logic                 err_reg, err_next;

  // Operand A as seen at the accept edge.
  logic [WIDTH-1:0]     a_in;
  assign a_in = bus.use_acc ? result_reg[WIDTH-1:0] : bus.a;

  logic [WIDTH-1:0]     not_w, and_w, or_w, xor_w;
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
      assign not_w[gi] = ~a_in[gi];
      assign and_w[gi] = a_in[gi] & bus.b[gi];
      assign or_w[gi]  = a_in[gi] | bus.b[gi];
      assign xor_w[gi] = a_in[gi] ^ bus.b[gi];
    end
  endgenerate

  logic [WIDTH:0]       add_sum;
  logic [WIDTH-1:0]     sub_diff;
  assign add_sum  = {1'b0, a_in} + {1'b0, bus.b};
  assign sub_diff = a_in - bus.b;

  // Shift-add multiply step: add the shifted multiplicand when the current multiplier bit is set.
  logic [2*WIDTH-1:0]   mul_sum;
  assign mul_sum = prod_reg + (mplier_reg[0] ? mcand_reg : {(2*WIDTH){1'b0}});

  // Restoring division step: the borrow bit of the trial subtraction decides the quotient bit.
  logic [WIDTH:0]       div_shift, div_trial;
  assign div_shift = {rem_reg, quo_reg[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opb_reg};

  // Factorial step keeps the full-width product so overflow into the top WIDTH bits is visible.
  logic [3*WIDTH-1:0]   fact_full;
  logic                 fact_ovf;
  assign fact_full = {{WIDTH{1'b0}}, prod_reg} * {{(2*WIDTH){1'b0}}, cnt_reg};
  assign fact_ovf  = |fact_full[3*WIDTH-1:2*WIDTH];

  logic                 step_last;
  assign step_last = (cnt_reg == WIDTH'(WIDTH - 1));

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    opa_next    = opa_reg;
    opb_next    = opb_reg;
    cnt_next    = cnt_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    prod_next   = prod_reg;
    rem_next    = rem_reg;
    quo_next    = quo_reg;
    result_next = result_reg;
    err_next    = err_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          op_next    = bus.op;
          opa_next   = a_in;
          opb_next   = bus.b;
          err_next   = 1'b0;
          state_next = DONE;
          case (bus.op)
            OP_CLR: result_next = {(2*WIDTH){1'b0}};
            OP_NOT: result_next = {{WIDTH{1'b0}}, not_w};
            OP_SHR: result_next = {{(WIDTH+1){1'b0}}, a_in[WIDTH-1:1]};
            OP_SHL: result_next = {{WIDTH{1'b0}}, a_in[WIDTH-2:0], 1'b0};
            OP_ADD: begin
              result_next = {{(WIDTH-1){1'b0}}, add_sum};
              err_next    = add_sum[WIDTH];
            end
            OP_SUB: begin
              result_next = {{WIDTH{1'b0}}, sub_diff};
              err_next    = (a_in < bus.b);
            end
            OP_AND: result_next = {{WIDTH{1'b0}}, and_w};
            OP_OR:  result_next = {{WIDTH{1'b0}}, or_w};
            OP_XOR: result_next = {{WIDTH{1'b0}}, xor_w};
            OP_MUL: begin
              state_next  = EXEC;
              mcand_next  = {{WIDTH{1'b0}}, a_in};
              mplier_next = bus.b;
              prod_next   = {(2*WIDTH){1'b0}};
              cnt_next    = {WIDTH{1'b0}};
            end
            OP_DIV: begin
              if (bus.b == {WIDTH{1'b0}}) begin
                result_next = {a_in, {WIDTH{1'b1}}};
                err_next    = 1'b1;
              end else begin
                state_next = EXEC;
                rem_next   = {WIDTH{1'b0}};
                quo_next   = a_in;
                cnt_next   = {WIDTH{1'b0}};
              end
            end
            OP_FACT: begin
              if (a_in <= WIDTH'(1)) begin
                result_next = {{(2*WIDTH-1){1'b0}}, 1'b1};
              end else begin
                state_next = EXEC;
                prod_next  = {{(2*WIDTH-1){1'b0}}, 1'b1};
                cnt_next   = WIDTH'(2);
              end
            end
            default: err_next = 1'b1;
          endcase
        end
      end

      EXEC: begin
        case (op_reg)
          OP_MUL: begin
            prod_next   = mul_sum;
            mcand_next  = {mcand_reg[2*WIDTH-2:0], 1'b0};
            mplier_next = {1'b0, mplier_reg[WIDTH-1:1]};
            cnt_next    = cnt_reg + 1'b1;
            if (step_last) begin
              result_next = mul_sum;
              state_next  = DONE;
            end
          end
          OP_DIV: begin
            if (!div_trial[WIDTH]) begin
              rem_next = div_trial[WIDTH-1:0];
              quo_next = {quo_reg[WIDTH-2:0], 1'b1};
            end else begin
              rem_next = div_shift[WIDTH-1:0];
              quo_next = {quo_reg[WIDTH-2:0], 1'b0};
            end
            cnt_next = cnt_reg + 1'b1;
            if (step_last) begin
              result_next = {rem_next, quo_next};
              state_next  = DONE;
            end
          end
          OP_FACT: begin
            prod_next = fact_full[2*WIDTH-1:0];
            cnt_next  = cnt_reg + 1'b1;
            if (fact_ovf || (cnt_reg == opa_reg)) begin
              result_next = fact_full[2*WIDTH-1:0];
              err_next    = fact_ovf;
              state_next  = DONE;
            end
          end
          default: state_next = DONE;
        endcase
      end

      DONE: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      op_reg     <= 4'd0;
      opa_reg    <= {WIDTH{1'b0}};
      opb_reg    <= {WIDTH{1'b0}};
      cnt_reg    <= {WIDTH{1'b0}};
      mcand_reg  <= {(2*WIDTH){1'b0}};
      mplier_reg <= {WIDTH{1'b0}};
      prod_reg   <= {(2*WIDTH){1'b0}};
      rem_reg    <= {WIDTH{1'b0}};
      quo_reg    <= {WIDTH{1'b0}};
      result_reg <= {(2*WIDTH){1'b0}};
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      opa_reg    <= opa_next;
      opb_reg    <= opb_next;
      cnt_reg    <= cnt_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      prod_reg   <= prod_next;
      rem_reg    <= rem_next;
      quo_reg    <= quo_next;
      result_reg <= result_next;
      err_reg    <= err_next;
    end
  end

  assign bus.busy   = (state_reg != IDLE);
  assign bus.done   = (state_reg == DONE);
  assign bus.result = result_reg;
  assign bus.err    = err_reg;

endmodule

// File: tb/tb_seq_alu_acc.sv
// Scoreboard bench for seq_alu_acc: the driver queues expected responses, and an
// independent monitor checks result, err and latency on every done pulse.
module tb_seq_alu_acc;

  logic clk;
  logic reset;
  int   cycle;
  int   total;
  int   bad;
  logic [31:0] acc;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          issue_cyc;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  seq_alu_acc_if #(.WIDTH(16)) bus ();

  seq_alu_acc #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
    end
  endtask

  // Reference model: plain integer arithmetic on the latched operands.
  function automatic void model(input logic [3:0] op, input logic [15:0] a16, input logic [15:0] b16,
                                input logic [31:0] acc_in, output logic [31:0] r,
                                output logic e, output int lat);
    longint unsigned la, lb, p;
    la  = 64'(a16);
    lb  = 64'(b16);
    r   = acc_in;
    e   = 1'b0;
    lat = 1;
    case (op)
      4'd0: r = 32'd0;
      4'd1: r = 32'(64'd65535 - la);
      4'd2: r = 32'(la / 2);
      4'd3: r = 32'((la * 2) % 65536);
      4'd4: begin p = la + lb; r = 32'(p); e = (p > 65535); end
      4'd5: begin r = 32'((la + 65536 - lb) % 65536); e = (la < lb); end
      4'd6: r = {16'd0, a16 & b16};
      4'd7: r = {16'd0, a16 | b16};
      4'd8: r = {16'd0, a16 ^ b16};
      4'd9: begin r = 32'(la * lb); lat = 17; end
      4'd10: begin
        if (lb == 0) begin
          r = {a16, 16'hFFFF};
          e = 1'b1;
        end else begin
          r   = 32'((la % lb) * 65536 + (la / lb));
          lat = 17;
        end
      end
      4'd11: begin
        if (la <= 1) begin
          r = 32'd1;
        end else begin
          p   = 1;
          lat = int'(la);
          for (longint unsigned k = 2; k <= la; k++) begin
            p = p * k;
            if (p >= 64'h1_0000_0000) begin
              e   = 1'b1;
              lat = int'(k);
              break;
            end
          end
          r = 32'(p);
        end
      end
      default: e = 1'b1;
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input logic ua, input logic [15:0] a, input logic [15:0] b,
                       input bit noise, input bit directed, input logic [31:0] dres,
                       input logic derr, input int dlat, input string nm);
    exp_t e;
    int   w;
    logic [15:0] a_eff;
    w = 0;
    while ((bus.busy || bus.done) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      total++;
      bad++;
      $display("FAIL %s_idle_wait: got busy=%0b required 0 within 100 cycles", nm, bus.busy);
    end
    a_eff = ua ? acc[15:0] : a;
    if (directed) begin
      e.res = dres;
      e.err = derr;
      e.lat = dlat;
    end else begin
      model(op, a_eff, b, acc, e.res, e.err, e.lat);
    end
    e.name      = nm;
    e.issue_cyc = cycle;
    acc         = e.res;
    sb_q.push_back(e);
    bus.op      = op;
    bus.use_acc = ua;
    bus.a       = a;
    bus.b       = b;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (noise) begin
      w = 0;
      while (bus.busy && w < 40) begin
        bus.start   = 1'($urandom_range(0, 1));
        bus.op      = 4'($urandom_range(0, 15));
        bus.use_acc = 1'($urandom_range(0, 1));
        bus.a       = 16'($urandom);
        bus.b       = 16'($urandom);
        @(negedge clk);
        w++;
      end
      bus.start = 1'b0;
    end
  endtask

  // Monitor: one line per completed transaction, compared against the queue head.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 result=0x%08h required no pending operation", bus.result);
      end else begin
        mon_e = sb_q.pop_front();
        $display("txn %s: result=0x%08h err=%0b latency=%0d", mon_e.name, bus.result, bus.err,
                 cycle - mon_e.issue_cyc);
        check({mon_e.name, "_result"}, 64'(bus.result), 64'(mon_e.res));
        check({mon_e.name, "_err"}, 64'(bus.err), 64'(mon_e.err));
        check({mon_e.name, "_latency"}, 64'(cycle - mon_e.issue_cyc), 64'(mon_e.lat));
      end
    end
  end

  initial begin
    int w;
    logic [3:0]  rop;
    logic        rua;
    logic [15:0] ra, rb;
    total       = 0;
    bad         = 0;
    acc         = 32'd0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 4'd0;
    bus.use_acc = 1'b0;
    bus.a       = 16'd0;
    bus.b       = 16'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_result", 64'(bus.result), 64'd0);
    check("reset_err", 64'(bus.err), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Abandon a MUL in its fifth EXEC cycle.
    issue(4'd9, 1'b0, 16'h1234, 16'h5678, 1'b0, 1'b0, 32'd0, 1'b0, 0, "mul_abort");
    repeat (4) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("midop_reset_busy", 64'(bus.busy), 64'd0);
    check("midop_reset_done", 64'(bus.done), 64'd0);
    check("midop_reset_result", 64'(bus.result), 64'd0);
    check("midop_reset_err", 64'(bus.err), 64'd0);
    sb_q.delete();
    acc = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(4'd4, 1'b0, 16'd2, 16'd3, 1'b0, 1'b1, 32'h0000_0005, 1'b0, 1, "add_after_reset");

    issue(4'd4, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 32'h0001_0000, 1'b1, 1, "add_carry");
    issue(4'd5, 1'b0, 16'd3, 16'd5, 1'b0, 1'b1, 32'h0000_FFFE, 1'b1, 1, "sub_borrow");
    issue(4'd9, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 32'hFFFE_0001, 1'b0, 17, "mul_max");
    issue(4'd10, 1'b0, 16'd100, 16'd7, 1'b1, 1'b1, 32'h0002_000E, 1'b0, 17, "div_100_7");
    issue(4'd10, 1'b0, 16'd100, 16'd0, 1'b0, 1'b1, 32'h0064_FFFF, 1'b1, 1, "div_by_zero");
    issue(4'd11, 1'b0, 16'd12, 16'd0, 1'b1, 1'b1, 32'h1C8C_FC00, 1'b0, 12, "fact_12");
    issue(4'd11, 1'b0, 16'd13, 16'd0, 1'b0, 1'b1, 32'h7328_CC00, 1'b1, 13, "fact_13");
    issue(4'd11, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 1, "fact_0");

    issue(4'd0, 1'b0, 16'h1234, 16'h5678, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1, "chain_clr");
    issue(4'd4, 1'b0, 16'd5, 16'd0, 1'b0, 1'b1, 32'h0000_0005, 1'b0, 1, "chain_add5");
    issue(4'd4, 1'b1, 16'hAAAA, 16'd3, 1'b0, 1'b1, 32'h0000_0008, 1'b0, 1, "chain_acc_add3");
    issue(4'd3, 1'b1, 16'hAAAA, 16'd0, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 1, "chain_acc_shl");
    issue(4'd13, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 1, "chain_reserved");

    // Randomised operations checked against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      rua = 1'($urandom_range(0, 1));
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      if (rop == 4'd11) begin
        rua = 1'b0;
        ra  = 16'($urandom_range(0, 14));
      end
      issue(rop, rua, ra, rb, 1'($urandom_range(0, 1)), 1'b0, 32'd0, 1'b0, 0,
            $sformatf("rnd%0d_op%0d", i, rop));
    end

    w = 0;
    while (sb_q.size() > 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending operations required 0", sb_q.size());
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_alu_acc.md
# seq_alu_acc

Parametrised, multi-cycle successor to the 16-bit combinational ALU. It executes one operation per start/done handshake and writes every result into an internal 2·WIDTH accumulator, which the next operation can use as operand A. Multiply, divide and factorial are iterative state-machine operations rather than wide combinational operators. Each operation reports a per-operation error flag. The block sits between the operand registers and the result/display path.

## Interface
- WIDTH, 16, operand width; accumulator and result are 2·WIDTH.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  request; accepted only in IDLE.
- op  in  4  opcode, latched at accept.
- use_acc  in  1  at accept, operand A = result[WIDTH-1:0] instead of a.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse; result and err are valid in that cycle.
- result  out  2·WIDTH  accumulator; updates only on the edge that enters DONE.
- err  out  1  error for the last operation; held until the next accept.

## Operation
- States: IDLE, EXEC, DONE.
  - IDLE → DONE for single-cycle operations.
  - IDLE → EXEC for iterative operations.
  - EXEC → DONE when the iteration finishes.
  - DONE → IDLE always.
- Accept happens when start=1 in IDLE. At accept: op, A and B are latched, and err is cleared. Later changes on a, b, op or use_acc have no effect.
- start is ignored in EXEC and DONE, with no queueing.
- Opcodes (A, B are the latched values; W-bit results are zero-extended to 2W):
  - 0 CLR: result=0, err=0.
  - 1 NOT: ~A.
  - 2 SHR: A>>1.
  - 3 SHL: (A<<1) mod 2^W.
  - 4 ADD: result = A+B as W+1 bits; err = carry out.
  - 5 SUB: (A−B) mod 2^W; err = (A<B).
  - 6 AND, 7 OR, 8 XOR: bitwise.
  - 9 MUL: shift-add, W EXEC cycles; full 2W product; err=0.
  - 10 DIV: restoring division, W EXEC cycles; result = {remainder, quotient}.
    - B=0: no EXEC; result = {A, all-ones}, err=1.
  - 11 FACT: one EXEC cycle per factor k=2..A; running product P (2W bits) = P·k.
    - The full 3W-bit product is checked each step. If any upper W bit is set: err=1, result = truncated product, and the block goes to DONE immediately.
    - A≤1: result=1, single-cycle.
  - 12–15 reserved: result unchanged, err=1, single-cycle.
- Opcodes 0–8, 12–15, DIV-by-zero and FACT with A≤1 are single-cycle.
- Reset value of every output is 0, and state returns to IDLE. Reset mid-operation abandons the operation; no done pulse is produced.

## Timing
- Latency is counted from the accept edge to the cycle in which done=1.
  - Single-cycle: 1.
  - MUL and DIV: W+1 (17 at W=16).
  - FACT, A≥2: A cycles, or fewer on overflow abort. At W=16, 13! aborts on its 12th EXEC cycle, giving done at cycle 13.
- busy rises in the cycle after accept and falls in the cycle after done.
- Minimum start-to-start spacing is 2 cycles, because a start during a DONE cycle is ignored.
- result holds its value throughout EXEC. Iteration registers are internal and are not visible on result.

## Test plan
- Reset during MUL, in the 5th EXEC cycle: busy, done, result and err are 0 immediately. The next ADD 2+3 gives result=0x00000005, done 1 cycle after accept.
- ADD 0xFFFF+0x0001 → result=0x00010000, err=1, done 1 cycle after accept. SUB 3−5 → result=0x0000FFFE, err=1.
- MUL 0xFFFF×0xFFFF → result=0xFFFE0001, err=0, done 17 cycles after accept. Toggle start and a during busy: no effect.
- DIV 100/7 → result=0x0002000E, done 17 cycles after accept. DIV 100/0 → result=0x0064FFFF, err=1, done 1 cycle after accept.
- FACT 12 → result=0x1C8CFC00, err=0, done 12 cycles after accept. FACT 13 → result=0x7328CC00, err=1, done 13 cycles after accept. FACT 0 → result=1, done 1 cycle after accept.
- Accumulator chain:
  - CLR → result 0.
  - ADD a=5, b=0 → 5.
  - use_acc=1 ADD b=3 → 8.
  - use_acc=1 SHL → 0x10.
  - Reserved op 13 → result stays 0x10, err=1.
